// File: rtl/cond_pkg.sv
// Shared condition-code, flag-index and flag-write encodings for the ARM-subset core.
package cond_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against stored {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
    cond_ex = 1'b1;
    case (cond_e'(cond))
      CC_EQ:   cond_ex = z;
      CC_NE:   cond_ex = ~z;
      CC_CS:   cond_ex = c;
      CC_CC:   cond_ex = ~c;
      CC_MI:   cond_ex = n;
      CC_PL:   cond_ex = ~n;
      CC_VS:   cond_ex = v;
      CC_VC:   cond_ex = ~v;
      CC_HI:   cond_ex = c & ~z;
      CC_LS:   cond_ex = ~c | z;
      CC_GE:   cond_ex = ge;
      CC_LT:   cond_ex = ~ge;
      CC_GT:   cond_ex = ~z & ge;
      CC_LE:   cond_ex = z | ~ge;
      // NV is executed unconditionally in this subset, same as AL
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Architectural flag register, condition evaluation and write-enable gating.
// Optional performance counters enabled by defining COND_PERF_CNT_EN.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0]  FLAG_RST = 4'b0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  logic [3:0] flags_q;
  logic       cond_ex;
  logic       wr_nz;
  logic       wr_cv;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    wr_nz = cond_ex & ~Stall & (|(FlagW & FW_NZ));
    wr_cv = cond_ex & ~Stall & (|(FlagW & (FW_ALL & ~FW_NZ)));
  end

  // N,Z and C,V halves update independently so logic ops keep C,V
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FLAG_RST;
    end else begin
      if (wr_nz) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (wr_cv) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_comb begin
    CondEx   = cond_ex;
    Flags    = flags_q;
    PCSrc    = PCS & cond_ex;
    RegWrite = RegW & cond_ex & ~NoWrite;
    MemWrite = MemW & cond_ex;
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (!Stall) begin
      if (cond_ex) exec_q   <= exec_q + CNT_ONE;
      else         squash_q <= squash_q + CNT_ONE;
    end
  end

  always_comb begin
    ExecCnt   = exec_q;
    SquashCnt = squash_q;
  end
`else
  always_comb begin
    ExecCnt   = '0;
    SquashCnt = '0;
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic; counter expectations follow COND_PERF_CNT_EN.
module tb_cond_logic;

  localparam int unsigned CNT_W = 32;
`ifdef COND_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             Stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt, SquashCnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exec_exp = 0;
  int squash_exp = 0;

  cond_logic #(.FLAG_RST(4'b0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .CondEx(CondEx), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_exec"},   64'(ExecCnt),   PERF ? 64'(exec_exp)   : 64'd0);
    check({tag, "_squash"}, 64'(SquashCnt), PERF ? 64'(squash_exp) : 64'd0);
  endtask

  // Advance one clock; cx is the hand-computed CondEx in effect at the edge
  task automatic tick(input logic cx);
    @(posedge clk);
    if (reset && !Stall) begin
      if (cx) exec_exp++;
      else    squash_exp++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af);
    Cond = c; FlagW = fw; ALUFlags = af;
    #1;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0;
    Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'b11;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_flags", 64'(Flags), 64'h0);
    check_cnt("rst");
    drive(4'b0000, 2'b11, 4'b1111);
    check("rst_eq_condex", 64'(CondEx), 64'd0);
    check("rst_pcsrc", 64'(PCSrc), 64'd0);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    drive(4'b1110, 2'b11, 4'b1111);
    @(negedge clk);
    check("rst_hold_flags", 64'(Flags), 64'h0);

    reset = 1'b1; PCS = 1'b0; MemW = 1'b0;
    drive(4'b1110, 2'b11, 4'b0100);
    check("al_regwrite", 64'(RegWrite), 64'd1);
    check("al_condex", 64'(CondEx), 64'd1);
    tick(1'b1);
    check("flags_0100", 64'(Flags), 64'h4);
    drive(4'b0000, 2'b00, 4'b0000);
    check("eq_after_write", 64'(CondEx), 64'd1);
    tick(1'b1);
    check_cnt("after_eq");

    drive(4'b1110, 2'b11, 4'b0110);
    tick(1'b1);
    check("flags_0110", 64'(Flags), 64'h6);
    drive(4'b1110, 2'b10, 4'b1000);
    tick(1'b1);
    check("nz_only", 64'(Flags), 64'hA);

    drive(4'b1110, 2'b11, 4'b1001);
    tick(1'b1);
    check("flags_1001", 64'(Flags), 64'h9);
    drive(4'b1010, 2'b00, 4'b0000);
    check("ge_nv_eq", 64'(CondEx), 64'd1);
    drive(4'b1011, 2'b00, 4'b0000);
    check("lt_nv_eq", 64'(CondEx), 64'd0);
    drive(4'b1100, 2'b00, 4'b0000);
    check("gt_1001", 64'(CondEx), 64'd1);
    tick(1'b1);

    drive(4'b1110, 2'b11, 4'b1000);
    tick(1'b1);
    drive(4'b1100, 2'b00, 4'b0000);
    check("gt_1000", 64'(CondEx), 64'd0);
    drive(4'b1101, 2'b00, 4'b0000);
    check("le_1000", 64'(CondEx), 64'd1);
    drive(4'b1000, 2'b00, 4'b0000);
    check("hi_1000", 64'(CondEx), 64'd0);
    drive(4'b1001, 2'b00, 4'b0000);
    check("ls_1000", 64'(CondEx), 64'd1);
    tick(1'b1);

    drive(4'b1110, 2'b11, 4'b0000);
    tick(1'b1);
    MemW = 1'b1;
    drive(4'b0000, 2'b11, 4'b1111);
    check("squash_condex", 64'(CondEx), 64'd0);
    check("squash_memwrite", 64'(MemWrite), 64'd0);
    tick(1'b0);
    check("squash_flags", 64'(Flags), 64'h0);
    check_cnt("squash");
    MemW = 1'b0;

    Stall = 1'b1;
    drive(4'b1110, 2'b11, 4'b0011);
    check("stall_regwrite", 64'(RegWrite), 64'd1);
    tick(1'b1);
    check("stall_flags", 64'(Flags), 64'h0);
    check_cnt("stall");
    Stall = 1'b0;
    tick(1'b1);
    check("unstall_flags", 64'(Flags), 64'h3);
    drive(4'b0010, 2'b00, 4'b0000);
    check("cs_0011", 64'(CondEx), 64'd1);
    drive(4'b0011, 2'b00, 4'b0000);
    check("cc_0011", 64'(CondEx), 64'd0);
    drive(4'b0110, 2'b00, 4'b0000);
    check("vs_0011", 64'(CondEx), 64'd1);
    drive(4'b0101, 2'b00, 4'b0000);
    check("pl_0011", 64'(CondEx), 64'd1);
    drive(4'b1111, 2'b00, 4'b0000);
    check("nv_always", 64'(CondEx), 64'd1);
    NoWrite = 1'b1; PCS = 1'b1;
    drive(4'b1110, 2'b11, 4'b0110);
    check("cmp_regwrite", 64'(RegWrite), 64'd0);
    check("cmp_pcsrc", 64'(PCSrc), 64'd1);
    tick(1'b1);
    check("cmp_flags", 64'(Flags), 64'h6);
    check_cnt("cmp");

    #2 reset = 1'b0;
    #1;
    check("async_rst_flags", 64'(Flags), 64'h0);
    exec_exp = 0; squash_exp = 0;
    check_cnt("async_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Consumer side of the ALU flag interface in the single-cycle ARM-subset processor.
- Registers ALUFlags {N,Z,C,V} into the architectural flag register, under write-enable from the decoder.
- Evaluates the 4-bit instruction condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW so that condition-failed instructions have no architectural side effects.
- Sits between the decoder, the ALU and the datapath write enables.

Parameters:
- FLAG_RST, 4'b0000, reset value of stored {N,Z,C,V}
- CNT_W, 32, width of the optional performance counters

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; flags and counters clear while low
- Stall  input  1  holds all state when high (for future multicycle use); outputs stay combinational
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, bit3=N … bit0=V
- FlagW  input  2  decoder flag-write request: [1] updates N,Z; [0] updates C,V
- PCS  input  1  decoder: instruction writes PC
- RegW  input  1  decoder: instruction writes register file
- MemW  input  1  decoder: instruction writes memory
- NoWrite  input  1  decoder: compare-class op (CMP/TST), suppresses RegWrite
- PCSrc  output  1  gated PCS
- RegWrite  output  1  gated RegW
- MemWrite  output  1  gated MemW
- Flags  output  4  current stored {N,Z,C,V}
- CondEx  output  1  condition passed this cycle
- ExecCnt  output  CNT_W  executed-instruction count (optional feature)
- SquashCnt  output  CNT_W  condition-failed count (optional feature)

Behaviour:
- Reset (reset=0, async): Flags=FLAG_RST; ExecCnt=0; SquashCnt=0. Combinational outputs follow their inputs with the reset flags applied.
- CondEx is combinational from Cond and stored Flags (never from ALUFlags in the same cycle). Mapping:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as 1
- Output gating, zero latency:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- Flag register update, on posedge clk when reset=1 and Stall=0:
  - if FlagW[1] & CondEx: N,Z <= ALUFlags[3:2]
  - if FlagW[0] & CondEx: C,V <= ALUFlags[1:0]
  - The halves are independent: logic ops (FlagW=10) leave C,V untouched.
- New flags are visible on Flags/CondEx one cycle after the write.
- Condition-failed instructions never update flags, including a failed CMP.
- Stall=1: flag register and counters hold; gated outputs still computed (the datapath is responsible for ignoring them).
- Reset asserted mid-cycle clears state immediately; a write on the same edge as reset deassertion is not required to take effect.

Optional Feature:
COND_PERF_CNT_EN
- Defined: ExecCnt increments by 1 each unstalled cycle with CondEx=1; SquashCnt increments by 1 each unstalled cycle with CondEx=0. Both counters wrap modulo 2^CNT_W and clear on reset.
- Undefined: no counter flops; ExecCnt and SquashCnt are tied to 0. Port list is unchanged.

Decomposition:
- Shared package cond_pkg:
  - condition-code enum (EQ…AL, NV)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - FlagW encodings FW_NONE=00, FW_NZ=10, FW_ALL=11
- One natural sub-module: cond_check, the purely combinational Cond×Flags→CondEx evaluator, reusable by the later pipelined core.

Test Plan:
- Reset low with random inputs -> Flags=0000, counters 0. Cond=0000 (EQ) -> CondEx=0, PCSrc/RegWrite/MemWrite=0.
- Cond=1110, FlagW=11, ALUFlags=0100, RegW=1 -> RegWrite=1 same cycle; next cycle Flags=0100 and Cond=0000 gives CondEx=1.
- Flags=0110, FlagW=10, ALUFlags=1000 -> next Flags=1010 (C preserved, V=0 preserved).
- Flags=1001 (N=V), Cond=1010 GE -> CondEx=1; Cond=1011 LT -> CondEx=0. Flags=1000, Cond=1100 GT -> 0.
- Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0; Flags remain 0000; SquashCnt +1 with COND_PERF_CNT_EN.
- Stall=1, FlagW=11, Cond=1110, ALUFlags=0011 -> Flags unchanged; Stall=0 next cycle -> Flags=0011. Then CMP (NoWrite=1, RegW=1) -> RegWrite=0.
